// File: rtl/line_memory.sv
// Dual-port line-granular main memory: 4x16-bit line reads on the instruction
// port, line reads/writes on the data port, each with a fixed-latency FSM.
//
//   state | meaning
//   IDLE  | no request, or just reset
//   BUSY  | request held, down-counting the remaining latency edges
//   DONE  | request served; ready high, read line driven until request drops
`timescale 1ns/1ps
module line_memory #(
    parameter int LATENCY   = 4,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_readM,
    input  logic [15:0] i_address,
    inout  wire  [63:0] i_data,
    output logic        i_ready,
    input  logic        d_readM,
    input  logic        d_writeM,
    input  logic [15:0] d_address,
    inout  wire  [63:0] d_data,
    output logic        d_ready
);

    localparam int         AW     = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } port_state_t;

    logic [15:0] mem [0:MEM_WORDS-1];

    port_state_t i_state, i_next;
    logic [3:0]  i_cnt, i_cnt_next;
    logic [15:0] i_addr_q, i_addr_next;
    logic        i_fire;
    logic [63:0] i_line;

    port_state_t d_state, d_next;
    logic [3:0]  d_cnt, d_cnt_next;
    logic [15:0] d_addr_q, d_addr_next;
    logic        d_wr_q, d_wr_next;
    logic        d_fire;
    logic        d_wr_now;
    logic        d_req;
    logic [63:0] d_line;

    // Word k of the line holding address a; upper bits wrap modulo MEM_WORDS.
    function automatic logic [AW-1:0] word_idx(input logic [15:0] a, input int k);
        return {a[AW-1:2], 2'(k)};
    endfunction

    always_comb begin
        i_next      = i_state;
        i_cnt_next  = i_cnt;
        i_addr_next = i_addr_q;
        i_fire      = 1'b0;
        unique case (i_state)
            ST_IDLE: begin
                if (i_readM) begin
                    i_addr_next = i_address;
                    if (LATENCY == 1) begin
                        i_next = ST_DONE;
                        i_fire = 1'b1;
                    end else begin
                        i_next     = ST_BUSY;
                        i_cnt_next = LAT_M1;
                    end
                end
            end
            ST_BUSY: begin
                if (!i_readM) begin
                    i_next     = ST_IDLE;
                    i_cnt_next = 4'd0;
                end else if (i_address != i_addr_q) begin
                    i_addr_next = i_address;
                    i_cnt_next  = LAT_M1;
                end else if (i_cnt == 4'd1) begin
                    i_next     = ST_DONE;
                    i_cnt_next = 4'd0;
                    i_fire     = 1'b1;
                end else begin
                    i_cnt_next = i_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!i_readM) i_next = ST_IDLE;
            end
            default: i_next = ST_IDLE;
        endcase
    end

    assign d_req = d_readM | d_writeM;

    always_comb begin
        d_next      = d_state;
        d_cnt_next  = d_cnt;
        d_addr_next = d_addr_q;
        d_wr_next   = d_wr_q;
        d_fire      = 1'b0;
        unique case (d_state)
            ST_IDLE: begin
                if (d_req) begin
                    d_addr_next = d_address;
                    d_wr_next   = d_writeM;
                    if (LATENCY == 1) begin
                        d_next = ST_DONE;
                        d_fire = 1'b1;
                    end else begin
                        d_next     = ST_BUSY;
                        d_cnt_next = LAT_M1;
                    end
                end
            end
            ST_BUSY: begin
                if (!d_req) begin
                    d_next     = ST_IDLE;
                    d_cnt_next = 4'd0;
                end else if (d_address != d_addr_q) begin
                    d_addr_next = d_address;
                    d_wr_next   = d_writeM;
                    d_cnt_next  = LAT_M1;
                end else if (d_cnt == 4'd1) begin
                    d_next     = ST_DONE;
                    d_cnt_next = 4'd0;
                    d_fire     = 1'b1;
                end else begin
                    d_cnt_next = d_cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!d_req) d_next = ST_IDLE;
            end
            default: d_next = ST_IDLE;
        endcase
    end

    // From IDLE (LATENCY=1) the op comes straight off the bus; otherwise the latched op.
    assign d_wr_now = (d_state == ST_IDLE) ? d_writeM : d_wr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_state  <= ST_IDLE;
            i_cnt    <= 4'd0;
            i_addr_q <= 16'd0;
            i_ready  <= 1'b0;
            d_state  <= ST_IDLE;
            d_cnt    <= 4'd0;
            d_addr_q <= 16'd0;
            d_wr_q   <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            i_state  <= i_next;
            i_cnt    <= i_cnt_next;
            i_addr_q <= i_addr_next;
            i_ready  <= (i_next == ST_DONE);
            d_state  <= d_next;
            d_cnt    <= d_cnt_next;
            d_addr_q <= d_addr_next;
            d_wr_q   <= d_wr_next;
            d_ready  <= (d_next == ST_DONE);
        end
    end

    // DONE is only entered with an unchanged address, so the live bus address
    // is the latched one. Nonblocking reads give the i-port pre-write data on
    // a same-edge hazard.
    always_ff @(posedge clk) begin
        if (reset_n && i_fire) begin
            for (int k = 0; k < 4; k++) i_line[16*k +: 16] <= mem[word_idx(i_address, k)];
        end
        if (reset_n && d_fire) begin
            if (d_wr_now) begin
                for (int k = 0; k < 4; k++) mem[word_idx(d_address, k)] <= d_data[16*k +: 16];
            end else begin
                for (int k = 0; k < 4; k++) d_line[16*k +: 16] <= mem[word_idx(d_address, k)];
            end
        end
    end

    assign i_data = (i_state == ST_DONE) ? i_line : 'z;
    assign d_data = (d_state == ST_DONE && !d_wr_q) ? d_line : 'z;

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: directed scenarios plus randomized traffic checked
// against a word-array reference model of the memory.
`timescale 1ns/1ps
module tb_line_memory;

    localparam int LAT   = 4;
    localparam int WORDS = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        i_readM = 1'b0;
    logic [15:0] i_address = 16'd0;
    wire  [63:0] i_data;
    logic        i_ready;
    logic        d_readM = 1'b0;
    logic        d_writeM = 1'b0;
    logic [15:0] d_address = 16'd0;
    wire  [63:0] d_data;
    logic        d_ready;
    logic        d_drive = 1'b0;
    logic [63:0] d_wdata = 64'd0;

    logic        l1_i_readM = 1'b0;
    logic [15:0] l1_i_address = 16'd0;
    wire  [63:0] l1_i_data;
    logic        l1_i_ready;
    logic        l1_d_readM = 1'b0;
    logic        l1_d_writeM = 1'b0;
    logic [15:0] l1_d_address = 16'd0;
    wire  [63:0] l1_d_data;
    logic        l1_d_ready;
    logic        l1_drive = 1'b0;
    logic [63:0] l1_wdata = 64'd0;

    assign d_data    = d_drive  ? d_wdata  : 'z;
    assign l1_d_data = l1_drive ? l1_wdata : 'z;

    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [0:WORDS-1];

    line_memory #(.LATENCY(LAT), .MEM_WORDS(WORDS)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .i_readM(i_readM), .i_address(i_address), .i_data(i_data), .i_ready(i_ready),
        .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
        .d_data(d_data), .d_ready(d_ready)
    );

    line_memory #(.LATENCY(1), .MEM_WORDS(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_readM(l1_i_readM), .i_address(l1_i_address), .i_data(l1_i_data), .i_ready(l1_i_ready),
        .d_readM(l1_d_readM), .d_writeM(l1_d_writeM), .d_address(l1_d_address),
        .d_data(l1_d_data), .d_ready(l1_d_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // An undriven bus reads as Z, or as 0 in a two-state simulator; driven lines are never 0.
    function automatic logic [63:0] released(input logic [63:0] v);
        return ($isunknown(v) || v == 64'd0) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom} | 64'h1;
    endfunction

    function automatic int line_base(input logic [15:0] a);
        return ((int'(a) / 4) * 4) % WORDS;
    endfunction

    function automatic logic [63:0] ref_line(input logic [15:0] a);
        int b;
        b = line_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [63:0] v);
        int b;
        b = line_base(a);
        for (int k = 0; k < 4; k++) ref_mem[b+k] = v[16*k +: 16];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic i_read(input logic [15:0] addr, input string tag);
        logic [63:0] exp;
        int n;
        exp = ref_line(addr);
        check({tag, " pre hiz"}, released(i_data), 64'd1);
        i_address = addr;
        i_readM = 1'b1;
        n = 0;
        do begin step(); n++; end while (!i_ready && n < 20);
        check({tag, " lat"}, 64'(n), 64'(LAT));
        check({tag, " data"}, i_data, exp);
        step();
        check({tag, " hold rdy"}, {63'd0, i_ready}, 64'd1);
        check({tag, " hold data"}, i_data, exp);
        i_readM = 1'b0;
        step();
        check({tag, " rel rdy"}, {63'd0, i_ready}, 64'd0);
        check({tag, " rel hiz"}, released(i_data), 64'd1);
    endtask

    task automatic d_read(input logic [15:0] addr, input string tag);
        logic [63:0] exp;
        int n;
        exp = ref_line(addr);
        d_address = addr;
        d_readM = 1'b1;
        n = 0;
        do begin step(); n++; end while (!d_ready && n < 20);
        check({tag, " lat"}, 64'(n), 64'(LAT));
        check({tag, " data"}, d_data, exp);
        step();
        check({tag, " hold data"}, d_data, exp);
        d_readM = 1'b0;
        step();
        check({tag, " rel rdy"}, {63'd0, d_ready}, 64'd0);
        check({tag, " rel hiz"}, released(d_data), 64'd1);
    endtask

    // wiggle: change the bus during DONE to expose any repeated commit.
    task automatic d_write(input logic [15:0] addr, input logic [63:0] data, input bit wiggle,
                           input string tag);
        int n;
        d_address = addr;
        d_wdata = data;
        d_drive = 1'b1;
        d_writeM = 1'b1;
        n = 0;
        do begin step(); n++; end while (!d_ready && n < 20);
        check({tag, " lat"}, 64'(n), 64'(LAT));
        ref_write(addr, data);
        if (wiggle) begin
            d_wdata = ~data;
            step();
            step();
            check({tag, " hold rdy"}, {63'd0, d_ready}, 64'd1);
        end
        d_writeM = 1'b0;
        d_drive = 1'b0;
        step();
        check({tag, " rel rdy"}, {63'd0, d_ready}, 64'd0);
        check({tag, " rel hiz"}, released(d_data), 64'd1);
    endtask

    task automatic both(input logic [15:0] ia, input logic [15:0] da, input logic [63:0] data,
                        input string tag);
        logic [63:0] exp_i;
        int n;
        exp_i = ref_line(ia);
        i_address = ia;
        i_readM = 1'b1;
        d_address = da;
        d_wdata = data;
        d_drive = 1'b1;
        d_writeM = 1'b1;
        n = 0;
        do begin step(); n++; end while (!(i_ready && d_ready) && n < 20);
        check({tag, " lat"}, 64'(n), 64'(LAT));
        check({tag, " i data"}, i_data, exp_i);
        ref_write(da, data);
        i_readM = 1'b0;
        d_writeM = 1'b0;
        d_drive = 1'b0;
        step();
        check({tag, " rel rdy"}, {62'd0, i_ready, d_ready}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] a;
        logic [63:0] v;

        repeat (3) @(posedge clk);
        #1;
        check("rst i_ready", {63'd0, i_ready}, 64'd0);
        check("rst d_ready", {63'd0, d_ready}, 64'd0);
        check("rst i hiz", released(i_data), 64'd1);
        check("rst d hiz", released(d_data), 64'd1);
        check("rst l1 rdy", {62'd0, l1_i_ready, l1_d_ready}, 64'd0);
        #2 reset_n = 1'b1;
        step();

        for (int l = 0; l < WORDS / 4; l++) d_write(16'(l * 4), rnd64(), 1'b0, "preload");

        d_write(16'h0020, 64'h4444_3333_2222_1111, 1'b0, "tp1 wr");
        i_read(16'h0022, "tp1 rd");

        d_write(16'h0040, 64'hDEAD_BEEF_0123_4567, 1'b1, "tp2 wr");
        check("tp2 mem40", 64'(u_dut.mem[16'h40]), 64'h4567);
        check("tp2 mem43", 64'(u_dut.mem[16'h43]), 64'hDEAD);
        d_read(16'h0043, "tp2 rd");

        both(16'h0010, 16'h0010, rnd64(), "hazard");
        i_read(16'h0010, "hazard after");

        d_address = 16'h0080;
        d_wdata = rnd64();
        d_drive = 1'b1;
        d_writeM = 1'b1;
        step();
        step();
        check("abort busy rdy", {63'd0, d_ready}, 64'd0);
        d_writeM = 1'b0;
        d_drive = 1'b0;
        step();
        check("abort rdy a", {63'd0, d_ready}, 64'd0);
        step();
        check("abort rdy b", {63'd0, d_ready}, 64'd0);
        d_read(16'h0080, "abort rd");

        i_address = 16'h0100;
        i_readM = 1'b1;
        step();
        step();
        d_address = 16'h0104;
        d_wdata = rnd64();
        d_drive = 1'b1;
        d_writeM = 1'b1;
        step();
        step();
        check("arst pre rdy", {63'd0, i_ready}, 64'd1);
        #3 reset_n = 1'b0;
        #1;
        check("arst i_ready", {63'd0, i_ready}, 64'd0);
        check("arst i hiz", released(i_data), 64'd1);
        check("arst d_ready", {63'd0, d_ready}, 64'd0);
        i_readM = 1'b0;
        d_writeM = 1'b0;
        d_drive = 1'b0;
        #1;
        check("arst d hiz", released(d_data), 64'd1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        step();
        d_read(16'h0104, "arst dropped wr");
        i_read(16'h0100, "arst fresh rd");

        i_address = 16'h0200;
        i_readM = 1'b1;
        step();
        step();
        check("addr chg busy", {63'd0, i_ready}, 64'd0);
        i_address = 16'h0300;
        n = 0;
        do begin step(); n++; end while (!i_ready && n < 20);
        check("addr chg lat", 64'(n), 64'(LAT));
        check("addr chg data", i_data, ref_line(16'h0300));
        i_readM = 1'b0;
        step();
        check("addr chg rel", {63'd0, i_ready}, 64'd0);

        i_read(16'hFFFC, "wrap");

        v = rnd64();
        l1_d_address = 16'h0017;
        l1_wdata = v;
        l1_drive = 1'b1;
        l1_d_writeM = 1'b1;
        step();
        check("lat1 wr rdy", {63'd0, l1_d_ready}, 64'd1);
        l1_d_writeM = 1'b0;
        l1_drive = 1'b0;
        step();
        check("lat1 wr rel", {63'd0, l1_d_ready}, 64'd0);
        l1_i_address = 16'h0004;
        l1_i_readM = 1'b1;
        step();
        check("lat1 rd rdy", {63'd0, l1_i_ready}, 64'd1);
        check("lat1 rd data", l1_i_data, v);
        l1_i_readM = 1'b0;
        step();
        check("lat1 rd rel", {63'd0, l1_i_ready}, 64'd0);
        check("lat1 rd hiz", released(l1_i_data), 64'd1);

        for (int it = 0; it < 150; it++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 3))
                0: i_read(a, "rnd ird");
                1: d_read(a, "rnd drd");
                2: d_write(a, rnd64(), 1'b0, "rnd dwr");
                default: both(a, ($urandom_range(0, 1) == 1) ? (a ^ 16'h0003) : 16'($urandom),
                              rnd64(), "rnd both");
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
